// File: rtl/unsigned_radix2_divider.sv
// Iterative restoring radix-2 unsigned divider, one quotient bit per clock.
// A start pulse launches an operation; done pulses once with the held results.
module unsigned_radix2_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  done,
  output logic                  divisor_is_zero
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  dz_q, dz_d;
  logic [DATA_WIDTH-1:0] quot_q, quot_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;

  logic [DATA_WIDTH:0]   pr_q, pr_d;
  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic [DATA_WIDTH-1:0] d_q, d_d;

  logic [DATA_WIDTH:0]   sh;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH:0]   pr_step;
  logic [DATA_WIDTH-1:0] q_step;
  logic                  unused_pr_msb;

  // The partial remainder stays below the divisor, so its top bit never feeds a result.
  assign unused_pr_msb = pr_q[DATA_WIDTH];

  always_comb begin
    sh   = {pr_q[DATA_WIDTH-1:0], q_q[DATA_WIDTH-1]};
    diff = sh - {1'b0, d_q};
    if (diff[DATA_WIDTH] == 1'b0) begin
      pr_step = diff;
      q_step  = {q_q[DATA_WIDTH-2:0], 1'b1};
    end else begin
      pr_step = sh;
      q_step  = {q_q[DATA_WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    pr_d    = pr_q;
    q_d     = q_q;
    d_d     = d_q;

    if (start) begin
      // A new start always wins, discarding any division still in flight.
      q_d   = dividend;
      d_d   = divisor;
      pr_d  = '0;
      cnt_d = '0;
      dz_d  = 1'b0;
      if (divisor == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
        dz_d    = 1'b1;
        quot_d  = '1;
        rem_d   = dividend;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == RUN) begin
      pr_d  = pr_step;
      q_d   = q_step;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
        quot_d  = q_step;
        rem_d   = pr_step[DATA_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  // Working registers are only meaningful while RUN, so they carry no reset.
  always_ff @(posedge clk) begin
    pr_q <= pr_d;
    q_q  <= q_d;
    d_q  <= d_d;
  end

  assign quotient        = quot_q;
  assign remainder       = rem_q;
  assign done            = done_q;
  assign divisor_is_zero = dz_q;

endmodule
